// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage.
// A boot-time byte stream is packed little-endian into an internal word array;
// once the image is complete the block answers each enabled fetch one cycle
// later, returning a NOP with addr_err for misaligned or out-of-range PCs.
module imem_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        addr_err,
    input  logic        load_start,
    input  logic        load_byte_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_done,
    output logic        load_ovf,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            byte_idx;
    // One extra bit so the address can sit at DEPTH (saturated, "full").
    logic [DEPTH_LOG2:0]   word_addr;
    logic [31:0]           asm_word;
    logic [31:0]           mem [DEPTH];

    logic                  byte_acc;
    logic                  word_wr;
    logic                  word_full;
    logic [31:0]           word_next;
    logic                  fetch_bad;
    logic [DEPTH_LOG2-1:0] fetch_idx;

    // Insert one byte into the word being assembled at the given lane.
    function automatic logic [31:0] place_byte(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // A fetch address is bad if it is not word aligned or points past the array.
    function automatic logic pc_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    // A byte only counts while loading; a simultaneous load_start discards it.
    assign byte_acc  = (state == ST_LOAD) && load_byte_valid && !load_start;
    // A word is committed when its top lane fills or the image ends early.
    assign word_wr   = byte_acc && ((byte_idx == 2'd3) || load_last);
    assign word_full = word_addr[DEPTH_LOG2];
    assign word_next = place_byte(asm_word, byte_idx, load_byte);
    assign fetch_bad = pc_bad(pc);
    assign fetch_idx = pc[DEPTH_LOG2+1:2];
    assign busy      = (state != ST_RUN);

    // Load sequencing: state, byte lane, word pointer, done pulse and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_idx  <= 2'd0;
            word_addr <= '0;
            asm_word  <= 32'h0;
            load_done <= 1'b0;
            load_ovf  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state     <= ST_LOAD;
                byte_idx  <= 2'd0;
                word_addr <= '0;
                asm_word  <= 32'h0;
                load_ovf  <= 1'b0;
            end else if (byte_acc) begin
                if (word_wr) begin
                    // Clear the assembly word so a short final word has zero upper bytes.
                    byte_idx <= 2'd0;
                    asm_word <= 32'h0;
                    if (word_full) begin
                        load_ovf <= 1'b1;
                    end else begin
                        word_addr <= word_addr + 1'b1;
                    end
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                    asm_word <= word_next;
                end
                if (load_last) begin
                    state     <= ST_RUN;
                    load_done <= 1'b1;
                end
            end
        end
    end

    // Word array write port; writes past the end are dropped, contents survive reset.
    always_ff @(posedge clk) begin
        if (word_wr && !word_full) begin
            mem[word_addr[DEPTH_LOG2-1:0]] <= word_next;
        end
    end

    // Fetch response: one-cycle read while running, held during stalls, idle otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else if (load_start || (state != ST_RUN)) begin
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else if (en) begin
            instr       <= fetch_bad ? 32'h0 : mem[fetch_idx];
            instr_valid <= 1'b1;
            addr_err    <= fetch_bad;
        end else begin
            addr_err    <= 1'b0;
        end
    end

endmodule
